// File: rtl/overlay_config_loader_if.sv
// ---------------------------------------------------------------------------
// overlay_config_loader_if
//   Byte stream between a configuration source and overlay_config_loader.
//   Carries the configuration bytes toward the loader (valid/ready) and the
//   readback bytes coming back from the scan chain (one-cycle valid strobe).
//
//   data_in        [7:0]  configuration byte (source -> loader)
//   data_valid            data_in valid        (source -> loader)
//   data_ready            loader accepts now   (loader -> source)
//   readback_data  [7:0]  captured chain bits  (loader -> source)
//   readback_valid        readback_data strobe (loader -> source)
//
//   master: configuration source / host side
//   slave : loader side
// ---------------------------------------------------------------------------
interface overlay_config_loader_if;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic [7:0] readback_data;
    logic       readback_valid;

    modport master (
        output data_in,
        output data_valid,
        input  data_ready,
        input  readback_data,
        input  readback_valid
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready,
        output readback_data,
        output readback_valid
    );
endinterface

// File: rtl/overlay_config_loader.sv
// ---------------------------------------------------------------------------
// overlay_config_loader
//   Serialises configuration bytes MSB-first into the overlay scan chain and
//   captures the bits falling out of the chain as readback bytes. One load
//   shifts exactly CHAIN_LENGTH bits; a trailing partial byte uses only the
//   top R bits of the byte and returns its readback right-aligned.
//
//   Parameters
//     CHAIN_LENGTH  scan-chain bits per load (1 .. 2^COUNT_WIDTH-1)
//     COUNT_WIDTH   width of the bit counter
//   Ports
//     clock         rising-edge clock
//     reset         synchronous, active-high
//     start         begin a load (honoured in IDLE or DONE only)
//     host          byte stream in / readback out (slave modport)
//     shift_enable  to overlay shift_enable
//     chain_in      to overlay shift_in
//     chain_out     from overlay shift_out
//     busy          high while waiting for or shifting a byte
//     done          high once the whole chain has been shifted
// ---------------------------------------------------------------------------
module overlay_config_loader #(
    parameter int CHAIN_LENGTH = 100,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    overlay_config_loader_if.slave  host,
    output logic                    shift_enable,
    output logic                    chain_in,
    input  logic                    chain_out,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] LAST_BIT = COUNT_WIDTH'(CHAIN_LENGTH - 1);

    state_t                 state;
    state_t                 state_next;
    logic [COUNT_WIDTH-1:0] bit_count;
    logic [3:0]             nbits;
    logic [7:0]             sreg;
    logic [7:0]             capture;
    logic                   chain_end;
    logic                   byte_end;

    // Both terminate conditions are evaluated on the pre-increment counts, so
    // the edge that performs the final shift is also the edge that leaves SHIFT.
    assign chain_end = (bit_count == LAST_BIT);
    assign byte_end  = (nbits == 4'd7) || chain_end;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and state-decoded outputs. Outputs depend on registered state
    // only (no input feeds shift_enable or chain_in combinationally).
    always_comb begin
        state_next      = state;
        host.data_ready = 1'b0;
        shift_enable    = 1'b0;
        chain_in        = 1'b0;
        busy            = 1'b0;
        done            = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_WAIT;
            end
            S_WAIT: begin
                host.data_ready = 1'b1;
                busy            = 1'b1;
                if (host.data_valid) state_next = S_SHIFT;
            end
            S_SHIFT: begin
                shift_enable = 1'b1;
                chain_in     = sreg[7];
                busy         = 1'b1;
                if (byte_end) state_next = chain_end ? S_DONE : S_WAIT;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) state_next = S_WAIT;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bit_count           <= '0;
            nbits               <= '0;
            sreg                <= '0;
            capture             <= '0;
            host.readback_data  <= '0;
            host.readback_valid <= 1'b0;
        end else begin
            host.readback_valid <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) bit_count <= '0;
                end
                S_WAIT: begin
                    if (host.data_valid) begin
                        sreg    <= host.data_in;
                        nbits   <= '0;
                        // Clearing here is what leaves the upper bits of a
                        // partial-byte readback at zero.
                        capture <= '0;
                    end
                end
                S_SHIFT: begin
                    sreg      <= {sreg[6:0], 1'b0};
                    capture   <= {capture[6:0], chain_out};
                    bit_count <= bit_count + COUNT_WIDTH'(1);
                    nbits     <= nbits + 4'd1;
                    if (byte_end) begin
                        host.readback_data  <= {capture[6:0], chain_out};
                        host.readback_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/overlay_config_loader.md
# overlay_config_loader

Byte-to-serial configuration loader that drives the overlay's scan chain. It accepts configuration bytes over a valid/ready handshake and shifts them MSB-first into the chain's serial input with `shift_enable` asserted. It simultaneously captures the bits leaving the chain's serial output and returns them as readback bytes. It sits between the host/bitstream source and the overlay grid, and is the writing end of the scan-chain interface.

## Interface
- `CHAIN_LENGTH`, 100: total scan-chain bits to shift per load; must be ≥1 and < 2^`COUNT_WIDTH`.
- `COUNT_WIDTH`, 16: width of the bit counter.
- `clock` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: synchronous, active-high; one clock, reset is synchronous and active-high.
- `start` input 1: begin a load; sampled only in IDLE or DONE.
- `data_in` input 8: configuration byte.
- `data_valid` input 1: `data_in` is valid.
- `data_ready` output 1: loader will accept `data_in` this cycle.
- `shift_enable` output 1: to overlay `shift_enable`.
- `chain_in` output 1: to overlay `shift_in`.
- `chain_out` input 1: from overlay `shift_out`.
- `readback_data` output 8: captured chain bits.
- `readback_valid` output 1: one-cycle strobe; `readback_data` valid.
- `busy` output 1: high in WAIT or SHIFT.
- `done` output 1: high in DONE.

## Operation
- State machine: IDLE, WAIT, SHIFT, DONE.
- IDLE: all outputs 0. `start`=1 → WAIT, `bit_count`←0.
- WAIT: `data_ready`=1. `data_valid`&`data_ready` → latch `data_in` into the 8-bit shift register `sreg`, `nbits`←0, clear the capture register → SHIFT.
- SHIFT: `shift_enable`=1 and `chain_in`=`sreg[7]` every cycle.
  - On each edge: `sreg`←`sreg<<1`; capture←{capture[6:0], `chain_out`}; `bit_count`++, `nbits`++.
  - Leave SHIFT at the edge where `nbits` reaches 8 or `bit_count` reaches `CHAIN_LENGTH`. At that edge:
    - `readback_data`←final capture value; `readback_valid`=1 for the next cycle only.
    - Go to DONE if `bit_count`=`CHAIN_LENGTH`, else to WAIT.
- Final partial byte (R=`CHAIN_LENGTH` mod 8, R≠0):
  - Only `data_in[7:8-R]` are shifted. The low bits are discarded.
  - Readback holds the captured bits in `readback_data[R-1:0]`. Upper bits are 0.
- DONE: `done`=1, held. `start`=1 → WAIT with `bit_count`←0, enabling a reload.
- `start` in WAIT or SHIFT is ignored. `data_valid` outside WAIT is ignored, and no byte is consumed.
- Readback order: the first bit captured is the bit at the chain output before any shift. After a full load, the readback stream equals the previously loaded configuration, byte-aligned identically.
- Counter: `bit_count` is `COUNT_WIDTH` bits. It never exceeds `CHAIN_LENGTH` and does not wrap.

## Timing
- Reset values:
  - state IDLE.
  - `data_ready`, `shift_enable`, `chain_in`, `readback_valid`, `busy`, `done` all 0.
  - `readback_data` 0, `bit_count` 0, `sreg` 0.
- `shift_enable` and `chain_in` are decoded from registered state only. They carry no combinational path from inputs.
- Byte accepted at edge N: first shift cycle is N+1 (`shift_enable` high during N+1..N+8). `readback_valid` is high in cycle N+9, coinciding with WAIT (`data_ready`=1).
- Throughput: 9 cycles per full byte when `data_valid` is held high. The final partial byte takes R+1 cycles.
- `start`→first `data_ready`: 1 cycle.
- Reset mid-SHIFT: `shift_enable` is 0 from the cycle after the reset edge. No `readback_valid` is issued. The partial chain contents are undefined, and a full reload is required.
- `CHAIN_LENGTH` multiple of 8: the last byte shifts 8 bits, then DONE.
- Simultaneous `reset` and `start`: reset wins.

## Test plan
- `CHAIN_LENGTH`=20, bytes 0xA5,0x3C,0xF0, `data_valid` held, overlay model initially zero:
  - `shift_enable` high for exactly 20 cycles.
  - Chain receives 10100101 00111100 1111.
  - Readbacks are 0x00,0x00,0x00 (the third valid strobe covers 4 bits).
  - `done`=1 after the third readback.
- Reload the same 20-bit chain with 0xFF,0xFF,0xFF after the first load:
  - Readbacks are 0xA5,0x3C,0x0F.
  - Final-byte readback is right-aligned.
- `CHAIN_LENGTH`=16, bytes 0x81,0x7E:
  - Exactly 16 shift cycles.
  - `readback_valid` strobes twice, in the cycles 9 and 18 after the first accept.
  - DONE entered with no partial byte.
- Back-pressure: drop `data_valid` for 5 cycles between bytes.
  - `shift_enable` stays 0 and `data_ready` stays 1 during the gap.
  - The chain pattern is unchanged versus the first scenario.
- Assert `reset` on the 4th shift cycle of the second byte:
  - Next cycle: all outputs 0, state IDLE.
  - `data_valid` is ignored until `start`.
  - A fresh load completes correctly.
- Pulse `start` and `data_valid` during SHIFT and DONE:
  - SHIFT: no effect on the bit count or byte consumption.
  - DONE: `start` restarts the load, and `bit_count` resets to 0.
